// File: rtl/matrix_show_ctrl_pkg.sv
// Shared types and constants for the SHOW query sequencer: FSM states,
// prompt codes, ASCII constants and the received-byte classifier.
package matrix_show_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_M,
    ST_WAIT_N,
    ST_WAIT_SEL,
    ST_PREP,
    ST_ARM,
    ST_WAIT_TX
  } state_e;

  localparam logic [1:0] PR_ASK_M   = 2'd0;
  localparam logic [1:0] PR_ASK_N   = 2'd1;
  localparam logic [1:0] PR_ASK_SEL = 2'd2;
  localparam logic [1:0] PR_ERR     = 2'd3;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    CC_WS,
    CC_DIGIT,
    CC_OTHER
  } char_class_e;

  function automatic char_class_e char_class(input logic [7:0] b);
    if (b == ASCII_SP || b == ASCII_CR || b == ASCII_LF) return CC_WS;
    if (b >= ASCII_0 && b <= ASCII_0 + 8'd9) return CC_DIGIT;
    return CC_OTHER;
  endfunction

endpackage

// File: rtl/matrix_show_ctrl_prompt_fifo.sv
// Two-entry prompt-code FIFO. Accepts up to two pushes per cycle (a before b);
// a pop in the same cycle frees space first, and pushes that do not fit are dropped.
module matrix_show_ctrl_prompt_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_a_i,
  input  logic [1:0] din_a_i,
  input  logic       push_b_i,
  input  logic [1:0] din_b_i,
  input  logic       pop_i,
  output logic [1:0] dout_o,
  output logic       empty_o,
  output logic       full_o
);

  logic [1:0][1:0] mem_q, mem_d;
  logic [1:0]      cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (pop_i && cnt_d != 2'd0) begin
      mem_d[0] = mem_d[1];
      cnt_d    = cnt_d - 2'd1;
    end
    if (push_a_i && cnt_d != 2'd2) begin
      if (cnt_d == 2'd0) mem_d[0] = din_a_i;
      else               mem_d[1] = din_a_i;
      cnt_d = cnt_d + 2'd1;
    end
    if (push_b_i && cnt_d != 2'd2) begin
      if (cnt_d == 2'd0) mem_d[0] = din_b_i;
      else               mem_d[1] = din_b_i;
      cnt_d = cnt_d + 2'd1;
    end
    if (flush_i) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout_o  = mem_q[0];
  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/matrix_show_ctrl.sv
// SHOW sequencer: parses an ASCII "m n s" query and drives the matrix store
// selection plus the ShowUartTx send/prompt start handshakes.
module matrix_show_ctrl
  import matrix_show_ctrl_pkg::*;
#(
  parameter int unsigned MAX_DIM        = 5,
  parameter int unsigned SLOTS          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000_000,
  parameter int unsigned CW             = $clog2(SLOTS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic [CW-1:0] store_count,
  input  logic          tx_busy,
  input  logic          line_busy,
  output logic [7:0]    req_m,
  output logic [7:0]    req_n,
  output logic [CW-1:0] cursor,
  output logic          send_start,
  output logic          prompt_start,
  output logic [1:0]    prompt_sel,
  output logic          err_pulse,
  output logic          active
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [7:0]    req_m_q, req_m_d, req_n_q, req_n_d;
  logic [CW-1:0] sel_q, sel_d, cursor_q, cursor_d, last_q, last_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          seen_q, seen_d, send_q, send_d, prompt_q, prompt_d, err_q, err_d;
  logic [1:0]    psel_q, psel_d;

  logic          push_a, push_b, flush, pop, f_empty, f_full;
  logic [1:0]    din_a, din_b, f_head;
  logic          is_digit, is_ws, rx_tok, tmo_hit;
  logic [7:0]    v8;

  assign is_digit = (char_class(rx_data) == CC_DIGIT);
  assign is_ws    = (char_class(rx_data) == CC_WS);
  assign v8       = rx_data - ASCII_0;
  assign rx_tok   = rx_done && !is_ws;
  assign tmo_hit  = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  // A registered start pulse reaches tx_busy one cycle late, so hold off
  // further launches while either pulse is still on the wire.
  assign pop = enable && !f_empty && !tx_busy && !line_busy && !prompt_q && !send_q &&
               state_q != ST_ARM && state_q != ST_WAIT_TX;

  always_comb begin
    state_d  = state_q;
    req_m_d  = req_m_q;
    req_n_d  = req_n_q;
    sel_d    = sel_q;
    cursor_d = cursor_q;
    last_d   = last_q;
    seen_d   = seen_q;
    send_d   = 1'b0;
    err_d    = 1'b0;
    push_a   = 1'b0;
    din_a    = PR_ASK_M;
    push_b   = 1'b0;
    din_b    = PR_ASK_M;
    flush    = 1'b0;
    tmo_d    = tmo_q + TW'(1);

    if (!enable) begin
      state_d = ST_IDLE;
      flush   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          push_a  = 1'b1;
          din_a   = PR_ASK_M;
          state_d = ST_WAIT_M;
        end
        ST_WAIT_M: begin
          if (rx_tok) begin
            if (is_digit && v8 >= 8'd1 && v8 <= 8'(MAX_DIM)) begin
              req_m_d = v8;
              push_a  = 1'b1;
              din_a   = PR_ASK_N;
              state_d = ST_WAIT_N;
            end else begin
              err_d  = 1'b1;
              push_a = 1'b1;
              din_a  = PR_ERR;
              push_b = 1'b1;
              din_b  = PR_ASK_M;
            end
          end
        end
        ST_WAIT_N: begin
          if (rx_tok) begin
            if (is_digit && v8 >= 8'd1 && v8 <= 8'(MAX_DIM)) begin
              req_n_d = v8;
              push_a  = 1'b1;
              din_a   = PR_ASK_SEL;
              state_d = ST_WAIT_SEL;
            end else begin
              err_d  = 1'b1;
              push_a = 1'b1;
              din_a  = PR_ERR;
              push_b = 1'b1;
              din_b  = PR_ASK_N;
            end
          end else if (tmo_hit) begin
            err_d   = 1'b1;
            push_a  = 1'b1;
            din_a   = PR_ASK_M;
            state_d = ST_WAIT_M;
          end
        end
        ST_WAIT_SEL: begin
          if (rx_tok) begin
            if (is_digit && v8 <= 8'(SLOTS)) begin
              sel_d   = CW'(v8);
              state_d = ST_PREP;
            end else begin
              err_d  = 1'b1;
              push_a = 1'b1;
              din_a  = PR_ERR;
            end
          end else if (tmo_hit) begin
            err_d   = 1'b1;
            push_a  = 1'b1;
            din_a   = PR_ASK_M;
            state_d = ST_WAIT_M;
          end
        end
        ST_PREP: begin
          if (store_count == '0 || sel_q > store_count) begin
            err_d   = 1'b1;
            push_a  = 1'b1;
            din_a   = PR_ERR;
            state_d = ST_WAIT_M;
          end else begin
            cursor_d = (sel_q == '0) ? '0 : sel_q - CW'(1);
            last_d   = (sel_q == '0) ? store_count - CW'(1) : sel_q - CW'(1);
            state_d  = ST_ARM;
          end
        end
        ST_ARM: begin
          if (!tx_busy && !line_busy && f_empty && !prompt_q) begin
            send_d  = 1'b1;
            seen_d  = 1'b0;
            state_d = ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          if (!seen_q) begin
            if (tx_busy) seen_d = 1'b1;
          end else if (!tx_busy) begin
            if (cursor_q == last_q) begin
              push_a  = 1'b1;
              din_a   = PR_ASK_M;
              state_d = ST_WAIT_M;
            end else begin
              cursor_d = cursor_q + CW'(1);
              state_d  = ST_ARM;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (state_d != state_q || rx_tok ||
        (state_q != ST_WAIT_N && state_q != ST_WAIT_SEL)) begin
      tmo_d = '0;
    end

    prompt_d = pop;
    psel_d   = pop ? f_head : psel_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_m_q  <= 8'd1;
      req_n_q  <= 8'd1;
      sel_q    <= '0;
      cursor_q <= '0;
      last_q   <= '0;
      tmo_q    <= '0;
      seen_q   <= 1'b0;
      send_q   <= 1'b0;
      prompt_q <= 1'b0;
      err_q    <= 1'b0;
      psel_q   <= PR_ASK_M;
    end else begin
      state_q  <= state_d;
      req_m_q  <= req_m_d;
      req_n_q  <= req_n_d;
      sel_q    <= sel_d;
      cursor_q <= cursor_d;
      last_q   <= last_d;
      tmo_q    <= tmo_d;
      seen_q   <= seen_d;
      send_q   <= send_d;
      prompt_q <= prompt_d;
      err_q    <= err_d;
      psel_q   <= psel_d;
    end
  end

  matrix_show_ctrl_prompt_fifo u_prompt_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (flush),
    .push_a_i (push_a && (!f_full || pop)),
    .din_a_i  (din_a),
    .push_b_i (push_b),
    .din_b_i  (din_b),
    .pop_i    (pop),
    .dout_o   (f_head),
    .empty_o  (f_empty),
    .full_o   (f_full)
  );

  assign req_m        = req_m_q;
  assign req_n        = req_n_q;
  assign cursor       = cursor_q;
  assign send_start   = send_q;
  assign prompt_start = prompt_q;
  assign prompt_sel   = psel_q;
  assign err_pulse    = err_q;
  assign active       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matrix_show_ctrl.sv
// Directed bench for matrix_show_ctrl with a simple busy-for-N-cycles transmitter responder.
module tb_matrix_show_ctrl;

  localparam int GAP      = 20;
  localparam int BUSY_LEN = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [2:0] store_count;
  logic       tx_busy;
  logic       line_busy;
  logic [7:0] req_m, req_n;
  logic [2:0] cursor;
  logic       send_start, prompt_start, err_pulse, active;
  logic [1:0] prompt_sel;

  int ncmp = 0;
  int nmis = 0;
  int nerr = 0;
  int plog[$];
  int slog[$];
  int exp_p[$];
  int exp_s[$];
  int busy_cnt = 0;

  always #5 clk = ~clk;

  matrix_show_ctrl #(.MAX_DIM(5), .SLOTS(4), .TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .store_count  (store_count),
    .tx_busy      (tx_busy),
    .line_busy    (line_busy),
    .req_m        (req_m),
    .req_n        (req_n),
    .cursor       (cursor),
    .send_start   (send_start),
    .prompt_start (prompt_start),
    .prompt_sel   (prompt_sel),
    .err_pulse    (err_pulse),
    .active       (active)
  );

  // Transmitter responder: busy rises the cycle after a start and lasts BUSY_LEN cycles.
  always @(posedge clk) begin
    if (send_start || prompt_start) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0)         busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    if (prompt_start === 1'b1) plog.push_back(int'(prompt_sel));
    if (send_start === 1'b1)   slog.push_back(int'(cursor));
    if (err_pulse === 1'b1)    nerr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_logs(input string tag);
    chk({tag, " n_prompts"}, plog.size(), exp_p.size());
    for (int i = 0; i < exp_p.size(); i++)
      chk({tag, " prompt_sel"}, (i < plog.size()) ? plog[i] : 99, exp_p[i]);
    chk({tag, " n_sends"}, slog.size(), exp_s.size());
    for (int i = 0; i < exp_s.size(); i++)
      chk({tag, " send_cursor"}, (i < slog.size()) ? slog[i] : 99, exp_s[i]);
  endtask

  task automatic clear_logs();
    plog.delete();
    slog.delete();
    nerr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " active"}, active, 0);
    chk({tag, " req_m"}, req_m, 1);
    chk({tag, " req_n"}, req_n, 1);
    chk({tag, " cursor"}, cursor, 0);
    chk({tag, " send_start"}, send_start, 0);
    chk({tag, " prompt_start"}, prompt_start, 0);
    chk({tag, " prompt_sel"}, prompt_sel, 0);
    chk({tag, " err_pulse"}, err_pulse, 0);
  endtask

  initial begin
    int waited;
    rst_n       = 1'b0;
    enable      = 1'b0;
    rx_data     = 8'h00;
    rx_done     = 1'b0;
    store_count = 3'd0;
    line_busy   = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: "2 2 0" with three stored 2x2 matrices -> send all three
    store_count = 3'd3;
    enable = 1'b1;
    repeat (10) @(negedge clk);
    send_byte("2"); send_byte(" "); send_byte("2"); send_byte(" "); send_byte("0");
    repeat (60) @(negedge clk);
    exp_p = '{0, 1, 2, 0};
    exp_s = '{0, 1, 2};
    chk_logs("t1");
    chk("t1 err_count", nerr, 0);
    chk("t1 req_m", req_m, 2);
    chk("t1 req_n", req_n, 2);

    // 2: "22\r2" -> only matrix 2 (cursor 1)
    clear_logs();
    send_byte("2"); send_byte("2"); send_byte(8'h0D); send_byte("2");
    repeat (40) @(negedge clk);
    exp_p = '{1, 2, 0};
    exp_s = '{1};
    chk_logs("t2");
    chk("t2 err_count", nerr, 0);

    // 3: fresh start, "6" then "x" in WAIT_M -> two errors, prompts 3,0 each
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    clear_logs();
    send_byte("6"); send_byte("x");
    repeat (10) @(negedge clk);
    exp_p = '{3, 0, 3, 0};
    exp_s.delete();
    chk_logs("t3");
    chk("t3 err_count", nerr, 2);
    chk("t3 req_m", req_m, 1);
    chk("t3 active", active, 1);

    // 4: "450" with nothing stored for 4x5 -> error in PREP, back to WAIT_M
    clear_logs();
    store_count = 3'd0;
    send_byte("4"); send_byte("5"); send_byte("0");
    repeat (10) @(negedge clk);
    exp_p = '{1, 2, 3};
    exp_s.delete();
    chk_logs("t4");
    chk("t4 err_count", nerr, 1);
    chk("t4 req_m", req_m, 4);
    chk("t4 req_n", req_n, 5);
    chk("t4 active", active, 1);

    // 5: "3" then silence -> timeout error exactly 100 cycles into WAIT_N
    clear_logs();
    @(negedge clk);
    rx_data = "3";
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (99) @(negedge clk);
    chk("t5 err_before_limit", err_pulse, 0);
    chk("t5 err_count_before", nerr, 0);
    @(negedge clk);
    chk("t5 err_at_limit", err_pulse, 1);
    repeat (30) @(negedge clk);
    exp_p = '{1, 0};
    exp_s.delete();
    chk_logs("t5");
    chk("t5 err_count", nerr, 1);
    chk("t5 req_m", req_m, 3);
    chk("t5 req_n", req_n, 5);

    // 6a: line_busy blocks ARM; release launches the send
    clear_logs();
    store_count = 3'd2;
    send_byte("3"); send_byte("3");
    line_busy = 1'b1;
    send_byte("0");
    repeat (10) @(negedge clk);
    chk("t6 sends_while_line_busy", slog.size(), 0);
    chk("t6 active_in_arm", active, 1);
    line_busy = 1'b0;
    waited = 0;
    while (slog.size() == 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("t6 first_send_seen", slog.size(), 1);
    chk("t6 first_cursor", (slog.size() > 0) ? slog[0] : 99, 0);

    // 6b: drop enable while the transmitter is busy -> IDLE next cycle, no more sends
    waited = 0;
    while (tx_busy !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("t6 tx_busy_rose", tx_busy, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("t6 idle_after_disable", active, 0);
    repeat (40) @(negedge clk);
    chk("t6 n_sends_after_disable", slog.size(), 1);
    chk("t6 n_prompts_after_disable", plog.size(), 2);

    // 6c: async reset while parked in ARM with cursor 1
    enable = 1'b1;
    repeat (20) @(negedge clk);
    send_byte("3"); send_byte("3");
    line_busy = 1'b1;
    send_byte("2");
    chk("t6 pre_reset_active", active, 1);
    chk("t6 pre_reset_cursor", cursor, 1);
    chk("t6 pre_reset_req_m", req_m, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6 async_reset");
    @(negedge clk);
    line_busy = 1'b0;
    enable = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end

endmodule
